rv32_dmem_responder: RTL
========================

// Module: rv32_dmem_responder
// PURPOSE
//   Data-memory target for the RV32 MEM stage: accepts one load/store request at a time over a
//   valid/ready request channel, applies a configurable wait-state delay, performs the word
//   access on an internal RAM with per-byte write strobes, and returns read data and an error
//   flag over a valid/ready response channel. It lets the pipeline see realistic memory latency.
// PARAMETERS
//   ADDR_WIDTH   8   word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  2   extra cycles between request accept and memory access (0..15)
// PORTS
//   clk             in   1   clock, all state on rising edge
//   reset_n         in   1   asynchronous, active-low reset
//   req_valid_in    in   1   request present
//   req_ready_out   out  1   responder can accept a request this cycle
//   req_write_in    in   1   1 = store, 0 = load
//   req_addr_in     in   32  byte address
//   req_wstrb_in    in   4   byte write enables, bit i -> bits [8i+7:8i]; ignored on loads
//   req_wdata_in    in   32  store data
//   resp_valid_out  out  1   response present
//   resp_ready_in   in   1   requester accepts response
//   resp_rdata_out  out  32  load data (0 for stores and errors)
//   resp_error_out  out  1   misaligned or out-of-range access
// BEHAVIOUR
//   Reset: state IDLE, wait counter 0, req_ready_out=1 after reset release (0 while reset_n=0),
//     resp_valid_out=0, resp_rdata_out=0, resp_error_out=0. RAM contents not reset.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: req_ready_out=1. Accept on req_valid_in && req_ready_out (edge T0): latch write,
//     addr, wstrb, wdata; counter <= WAIT_CYCLES. Next state WAIT, or with WAIT_CYCLES=0 the
//     access is performed at T0 and next state is RESP.
//   - WAIT: req_ready_out=0. Counter decrements each edge; the edge on which counter==1 performs
//     the access and moves to RESP. Access edge is always T0+WAIT_CYCLES.
//   - RESP: resp_valid_out=1; rdata/error held stable until resp_valid_out && resp_ready_in;
//     that edge returns to IDLE and clears resp_valid_out, resp_rdata_out, resp_error_out.
//   - req_ready_out=0 in WAIT and RESP; no request accepted in the response-handshake cycle.
//     Max throughput: one transaction per WAIT_CYCLES+2 cycles with resp_ready_in tied high.
//   Latency: resp_valid_out is first high in the cycle after edge T0+WAIT_CYCLES.
//   Access rules:
//   - word index = req_addr_in[ADDR_WIDTH+1:2].
//   - error if req_addr_in[1:0]!=0 or req_addr_in[31:ADDR_WIDTH+2]!=0: no RAM read or write,
//     resp_rdata_out=0, resp_error_out=1.
//   - store: only bytes whose wstrb bit is 1 are updated; wstrb=0000 is a legal no-op store
//     (error=0). Response rdata=0.
//   - load: resp_rdata_out = full 32-bit word at the index as it stood at the access edge.
//   - requester changing req_* while req_ready_out=0 has no effect (signals latched at accept).
//   Reset mid-operation: asserting reset_n=0 in WAIT abandons the request (store not performed
//   if access edge not reached); in RESP the pending response is dropped; no response after reset.
// TESTING
//   1 Reset: reset_n=0 with req_valid_in=1 -> req_ready_out=0, resp_valid_out=0; release ->
//     req_ready_out=1, nothing accepted before release.
//   2 Store/load: store 0xDEADBEEF to 0x10 wstrb=1111, then load 0x10 -> rdata=0xDEADBEEF,
//     error=0, resp_valid_out high exactly 3 cycles after each accept edge (WAIT_CYCLES=2).
//   3 Strobes: after case 2 store 0x00AA0055 to 0x10 wstrb=0101 -> load returns 0xDEAA BE55.
//   4 Errors: load 0x12 -> error=1, rdata=0; store to 0x400 (ADDR_WIDTH=8) -> error=1 and
//     word 0 unchanged on reload.
//   5 Backpressure: hold resp_ready_in=0 for 5 cycles -> resp_valid_out and rdata stable,
//     req_ready_out=0, new req_valid_in ignored; release -> IDLE the next cycle.
//   6 Reset mid-WAIT: store 0x12345678 to 0x20, pulse reset_n low 1 cycle after accept ->
//     no response; reload 0x20 returns prior contents; also rerun 2 with WAIT_CYCLES=0 ->
//     resp_valid_out high 1 cycle after accept.

Source files
------------

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: wait-stated word RAM target with valid/ready request and response channels
module rv32_dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [3:0]  req_wstrb_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] resp_rdata_out,
  output logic        resp_error_out
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [3:0]  cnt;
  logic        w_q;
  logic [31:0] a_q, d_q;
  logic [3:0]  s_q;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic        a_w, a_err, acc, accept;
  logic [31:0] a_addr, a_d, rd_val;
  logic [3:0]  a_s;
  logic [ADDR_WIDTH-1:0] idx;
  // Access operands come straight from the request port when a zero-wait access happens at accept
  always_comb begin
    accept = req_valid_in && req_ready_out;
    a_w    = (state == S_IDLE) ? req_write_in : w_q;
    a_addr = (state == S_IDLE) ? req_addr_in  : a_q;
    a_s    = (state == S_IDLE) ? req_wstrb_in : s_q;
    a_d    = (state == S_IDLE) ? req_wdata_in : d_q;
    idx    = a_addr[ADDR_WIDTH+1:2];
    a_err  = (|a_addr[1:0]) || (|a_addr[31:ADDR_WIDTH+2]);
    acc    = (state == S_IDLE) ? (accept && WAIT_CYCLES == 0) : (state == S_WAIT && cnt == 4'd1);
    rd_val = (a_err || a_w) ? 32'h0 : mem[idx];
  end
  // Byte-strobed store on the access edge; erroneous accesses never touch the RAM
  always_ff @(posedge clk) begin
    if (acc && a_w && !a_err)
      for (int i = 0; i < 4; i++)
        if (a_s[i]) mem[idx][8*i +: 8] <= a_d[8*i +: 8];
  end
  // Request/wait/response sequencing with registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      req_ready_out  <= 1'b0;
      resp_valid_out <= 1'b0;
      resp_rdata_out <= 32'h0;
      resp_error_out <= 1'b0;
      w_q            <= 1'b0;
      a_q            <= 32'h0;
      s_q            <= 4'h0;
      d_q            <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready_out <= 1'b1;
          if (accept) begin
            w_q           <= req_write_in;
            a_q           <= req_addr_in;
            s_q           <= req_wstrb_in;
            d_q           <= req_wdata_in;
            cnt           <= 4'(WAIT_CYCLES);
            req_ready_out <= 1'b0;
            state         <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            if (WAIT_CYCLES == 0) begin
              resp_valid_out <= 1'b1;
              resp_rdata_out <= rd_val;
              resp_error_out <= a_err;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (acc) begin
            state          <= S_RESP;
            resp_valid_out <= 1'b1;
            resp_rdata_out <= rd_val;
            resp_error_out <= a_err;
          end
        end
        S_RESP: begin
          if (resp_ready_in) begin
            state          <= S_IDLE;
            req_ready_out  <= 1'b1;
            resp_valid_out <= 1'b0;
            resp_rdata_out <= 32'h0;
            resp_error_out <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
